vga_frame_fetch: RTL and testbench
==================================

// Module: vga_frame_fetch
// PURPOSE
//  Downstream of vga_sequencer: streams the framebuffer from memory into a pixel FIFO
//  and drives RGB for each visible pixel. Burst reads on a req/ack + rvalid interface,
//  triggered by start_frame; pops one word per pixel_en strobe in the visible region.
// PARAMETERS
//  FIFO_DEPTH   64      pixel FIFO entries (power of 2, >= 2*BURST_LEN)
//  BURST_LEN    8       32-bit words per memory burst (power of 2)
//  FB_WORDS     307200  words per frame (640x480); multiple of BURST_LEN
// PORTS
//  clk                in   1   system clock (50 MHz)
//  reset              in   1   synchronous, active-high
//  fetch_en           in   1   enable fetching; low = finish current burst, then idle
//  fb_base            in   32  framebuffer byte address; sampled at frame start
//  start_frame        in   1   from vga_sequencer (level, high while its pc==0)
//  in_visible_region  in   1   from vga_sequencer
//  pixel_en           in   1   from vga_sequencer, high every other clk
//  mem_req            out  1   burst read request
//  mem_addr           out  32  burst start byte address
//  mem_ack            in   1   request accepted this clk
//  mem_rvalid         in   1   read beat valid
//  mem_rdata          in   32  read beat data, {8'x, R[23:16], G[15:8], B[7:0]}
//  red, green, blue   out  8   registered pixel colour
//  underflow          out  1   sticky: visible pixel found FIFO empty; cleared at frame start
// BEHAVIOUR
//  - Reset: FSM=IDLE, FIFO empty, mem_req=0, mem_addr=0, RGB=0, underflow=0.
//  - frame_start_pulse = start_frame && !start_frame_q (one clk per rising edge).
//  - On frame_start_pulse with fetch_en=1: FIFO flushed same clk, underflow cleared,
//    fetch_addr<=fb_base, words_left<=FB_WORDS; FSM -> REQUEST (from IDLE/REQUEST/DONE),
//    or -> DRAIN from RECEIVE (remaining beats of in-flight burst discarded, then REQUEST).
//    If pulse arrives while mem_req=1 un-acked, request is held until ack, then DRAIN.
//  - FSM: IDLE, REQUEST, RECEIVE, DRAIN, DONE.
//    REQUEST: assert mem_req when free_entries >= BURST_LEN; mem_addr=fetch_addr.
//      mem_req/mem_addr held stable until mem_ack; on ack -> RECEIVE, beat_cnt=0.
//    RECEIVE: each mem_rvalid pushes mem_rdata (never overflows: space reserved).
//      At beat BURST_LEN-1: fetch_addr+=4*BURST_LEN, words_left-=BURST_LEN;
//      -> DONE if words_left now 0, IDLE if fetch_en=0, else REQUEST.
//    DRAIN: count BURST_LEN beats, no pushes; -> REQUEST (restart) or IDLE if !fetch_en.
//    DONE: wait for next frame_start_pulse. IDLE: wait for pulse with fetch_en=1.
//  - Only one burst outstanding. fetch_addr wraps mod 2^32; no other alignment checks.
//  - Pop: pixel_en && in_visible_region && !empty -> pop; RGB <= word fields next clk.
//    pixel_en && in_visible_region && empty -> RGB <= 0, underflow <= 1.
//    pixel_en && !in_visible_region -> RGB <= 0. RGB holds when pixel_en=0.
//  - Simultaneous push and pop on same clk allowed at any level incl. empty/full;
//    pop from empty is never performed (push data not bypassed).
//  - Flush wins over same-clk push/pop; the popped pixel that clk outputs 0.
//  - Latency: pixel word to RGB = 1 clk after popping pixel_en edge.
//  - Reset mid-burst: all state cleared; memory side must also be reset.
// TESTING
//  1 Reset then idle: no start_frame 100 clks -> mem_req=0, RGB=0, underflow=0.
//  2 FB_WORDS=16,BURST_LEN=8, fb_base=0x1000, ack after 3 clks, data=index ->
//    exactly two requests at 0x1000 and 0x1020, FSM DONE, 16 visible pixels out in order.
//  3 Backpressure: FIFO_DEPTH=16, no visible pixels -> after 2 bursts mem_req stays 0;
//    pop 8 -> third request issued.
//  4 Underflow: visible region before any data returns -> RGB=0, underflow=1;
//    next frame_start_pulse -> underflow=0.
//  5 Restart mid-burst: pulse after 3 of 8 beats, fb_base=0x2000 -> 5 beats dropped,
//    FIFO empty, next request at 0x2000; first pixel is word 0 of new frame.
//  6 fetch_en dropped mid-burst -> burst completes, FSM IDLE, no further mem_req.

Source files
------------

// File: rtl/vga_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_fetch
// Description : Burst-reads the framebuffer into a pixel FIFO and drives one
//               registered RGB triple per visible pixel strobe.
// Revision    : 1.0
// ============================================================================
module vga_frame_fetch #(
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN  = 8,
    parameter int FB_WORDS   = 307200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [31:0] fb_base,
    input  logic        start_frame,
    input  logic        in_visible_region,
    input  logic        pixel_en,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int C_LAST_INT = BURST_LEN - 1;
    localparam int C_ONE_INT  = 1;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_REQUEST = 3'd1;
    localparam logic [2:0] c_RECEIVE = 3'd2;
    localparam logic [2:0] c_DRAIN   = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic [AW:0]   c_DEPTH       = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   c_BURST       = BURST_LEN[AW:0];
    localparam logic [AW-1:0] c_PTR_ONE     = C_ONE_INT[AW-1:0];
    localparam logic [BW-1:0] c_BEAT_ONE    = C_ONE_INT[BW-1:0];
    localparam logic [BW-1:0] c_LAST_BEAT   = C_LAST_INT[BW-1:0];
    localparam logic [31:0]   c_FB_WORDS    = 32'(FB_WORDS);
    localparam logic [31:0]   c_BURST_WORDS = 32'(BURST_LEN);
    localparam logic [31:0]   c_BURST_BYTES = 32'(4 * BURST_LEN);

    logic [2:0]    r_state;
    logic          r_start_q;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_words_left;
    logic [BW-1:0] r_beat_cnt;
    logic          r_restart_pend;

    logic [23:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [7:0]    r_red;
    logic [7:0]    r_green;
    logic [7:0]    r_blue;
    logic          r_underflow;

    logic          w_frame_pulse;
    logic          w_restart;
    logic          w_empty;
    logic [AW:0]   w_free;
    logic          w_can_req;
    logic          w_last_beat;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_words_next;
    logic          w_unused_rdata;

    assign w_frame_pulse  = start_frame & ~r_start_q;
    assign w_restart      = w_frame_pulse & fetch_en;
    assign w_empty        = (r_count == '0);
    assign w_free         = c_DEPTH - r_count;
    assign w_can_req      = (w_free >= c_BURST);
    assign w_last_beat    = mem_rvalid && (r_beat_cnt == c_LAST_BEAT);
    assign w_words_next   = r_words_left - c_BURST_WORDS;
    assign w_unused_rdata = ^mem_rdata[31:24];

    // Space for a whole burst is reserved before requesting, so pushes never overflow.
    assign w_push = (r_state == c_RECEIVE) && mem_rvalid && !w_restart;
    assign w_pop  = pixel_en && in_visible_region && !w_empty && !w_restart;

    assign mem_req   = r_req;
    assign mem_addr  = r_addr;
    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;
    assign underflow = r_underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_start_q      <= 1'b0;
            r_req          <= 1'b0;
            r_addr         <= '0;
            r_fetch_addr   <= '0;
            r_words_left   <= '0;
            r_beat_cnt     <= '0;
            r_restart_pend <= 1'b0;
        end else begin
            r_start_q <= start_frame;
            if (w_restart) begin
                r_fetch_addr <= fb_base;
                r_words_left <= c_FB_WORDS;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_restart) r_state <= c_REQUEST;
                end
                c_REQUEST: begin
                    if (r_req) begin
                        // An issued request must complete; a restart behind it drains its beats.
                        if (mem_ack) begin
                            r_req          <= 1'b0;
                            r_beat_cnt     <= '0;
                            r_restart_pend <= 1'b0;
                            r_state        <= (r_restart_pend || w_restart) ? c_DRAIN : c_RECEIVE;
                        end else if (w_restart) begin
                            r_restart_pend <= 1'b1;
                        end
                    end else if (!w_restart) begin
                        if (!fetch_en) begin
                            r_state <= c_IDLE;
                        end else if (w_can_req) begin
                            r_req  <= 1'b1;
                            r_addr <= r_fetch_addr;
                        end
                    end
                end
                c_RECEIVE: begin
                    if (mem_rvalid) r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
                    if (w_restart) begin
                        r_state <= w_last_beat ? c_REQUEST : c_DRAIN;
                    end else if (w_last_beat) begin
                        r_fetch_addr <= r_fetch_addr + c_BURST_BYTES;
                        r_words_left <= w_words_next;
                        if (w_words_next == '0)
                            r_state <= c_DONE;
                        else if (!fetch_en)
                            r_state <= c_IDLE;
                        else
                            r_state <= c_REQUEST;
                    end
                end
                c_DRAIN: begin
                    if (mem_rvalid) r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
                    if (w_last_beat) r_state <= fetch_en ? c_REQUEST : c_IDLE;
                end
                c_DONE: begin
                    if (w_restart) r_state <= c_REQUEST;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= mem_rdata[23:0];
    end

    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (pixel_en) begin
                if (w_pop) begin
                    r_red   <= r_mem[r_rd_ptr][23:16];
                    r_green <= r_mem[r_rd_ptr][15:8];
                    r_blue  <= r_mem[r_rd_ptr][7:0];
                end else begin
                    r_red   <= '0;
                    r_green <= '0;
                    r_blue  <= '0;
                end
                if (in_visible_region && w_empty) r_underflow <= 1'b1;
            end
            // Frame start clearing takes priority over a same-cycle underflow.
            if (w_frame_pulse) r_underflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_fetch
// Description : Directed self-checking bench for vga_frame_fetch with a
//               burst memory responder (data = word address).
// Revision    : 1.0
// ============================================================================
module tb_vga_frame_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] fb_base;
    logic        start_frame;
    logic        in_visible_region;
    logic        pixel_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    int n_req          = 0;
    int n_done         = 0;
    int beats_total    = 0;
    int beats_in_burst = 0;
    int beat_gate      = 8;
    bit gate_release   = 1'b0;
    logic [31:0] req_addr [32];

    vga_frame_fetch #(
        .FIFO_DEPTH (16),
        .BURST_LEN  (8),
        .FB_WORDS   (24)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_en          (fetch_en),
        .fb_base           (fb_base),
        .start_frame       (start_frame),
        .in_visible_region (in_visible_region),
        .pixel_en          (pixel_en),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .red               (red),
        .green             (green),
        .blue              (blue),
        .underflow         (underflow)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int cur_count(input int sel);
        case (sel)
            0:       return n_req;
            1:       return beats_total;
            2:       return beats_in_burst;
            default: return n_done;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int sel, input int target);
        int t = 0;
        while (cur_count(sel) < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(cur_count(sel) >= target), 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pixel(input bit vis);
        @(negedge clk);
        pixel_en          = 1'b1;
        in_visible_region = vis;
        @(negedge clk);
        pixel_en          = 1'b0;
        in_visible_region = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [23:0] exp);
        pixel(1'b1);
        check(tag, {8'h00, red, green, blue}, {8'h00, exp});
    endtask

    task automatic frame_pulse(input logic [31:0] base);
        @(negedge clk);
        fb_base     = base;
        start_frame = 1'b1;
        tick(3);
        start_frame = 1'b0;
    endtask

    // Memory model: ack two clocks after the request is seen, then BURST_LEN beats
    // of {8'hAA, word address}; beats past the latched gate stall until released.
    initial begin : responder
        logic [31:0] a;
        int          cur_gate;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                a = mem_addr;
                repeat (2) begin
                    @(negedge clk);
                    check("req_held", 32'(mem_req), 32'd1);
                    check("req_addr_held", mem_addr, a);
                end
                mem_ack            = 1'b1;
                req_addr[n_req]    = a;
                cur_gate           = beat_gate;
                beats_in_burst     = 0;
                n_req++;
                @(negedge clk);
                mem_ack = 1'b0;
                check("req_drop_after_ack", 32'(mem_req), 32'd0);
                while (beats_in_burst < 8) begin
                    if (gate_release) cur_gate = 8;
                    if (beats_in_burst < cur_gate) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = {8'hAA, a[25:2] + 24'(beats_in_burst)};
                        beats_in_burst++;
                        beats_total++;
                    end else begin
                        mem_rvalid = 1'b0;
                    end
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
                n_done++;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0;
        int d0;
        int b0;
        bit saw_req;

        reset             = 1'b1;
        fetch_en          = 1'b1;
        fb_base           = '0;
        start_frame       = 1'b0;
        in_visible_region = 1'b0;
        pixel_en          = 1'b0;
        tick(3);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rgb", {8'h00, red, green, blue}, 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        reset = 1'b0;

        // Idle with no frame start
        saw_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req) saw_req = 1'b1;
        end
        check("idle_no_req", 32'(saw_req), 32'd0);
        check("idle_rgb", {8'h00, red, green, blue}, 32'd0);
        check("idle_underflow", 32'(underflow), 32'd0);

        // Full frame at 0x1000 with backpressure after two bursts
        b0 = beats_total;
        frame_pulse(32'h1000);
        wait_cnt("wait_two_bursts", 1, b0 + 16);
        tick(30);
        check("bp_req_low", 32'(mem_req), 32'd0);
        check("bp_req_count", 32'(n_req), 32'd2);
        check("req0_addr", req_addr[0], 32'h1000);
        check("req1_addr", req_addr[1], 32'h1020);
        for (int i = 0; i < 8; i++) pop_expect("f1_pixel", 24'h400 + 24'(i));
        tick(2);
        check("rgb_hold", {8'h00, red, green, blue}, 32'h0000_0407);
        wait_cnt("wait_third_req", 0, 3);
        check("req2_addr", req_addr[2], 32'h1040);
        wait_cnt("wait_third_burst", 1, b0 + 24);
        for (int i = 8; i < 24; i++) pop_expect("f1_pixel", 24'h400 + 24'(i));
        tick(40);
        check("done_no_more_req", 32'(n_req), 32'd3);
        check("f1_no_underflow", 32'(underflow), 32'd0);
        pixel(1'b0);
        check("blank_rgb", {8'h00, red, green, blue}, 32'd0);
        pixel(1'b1);
        check("empty_rgb", {8'h00, red, green, blue}, 32'd0);
        check("empty_underflow", 32'(underflow), 32'd1);

        // Underflow before data arrives, then cleared by the next frame start
        r0 = n_req;
        d0 = n_done;
        b0 = beats_total;
        frame_pulse(32'h3000);
        check("uf_cleared", 32'(underflow), 32'd0);
        pixel(1'b1);
        check("uf_rgb", {8'h00, red, green, blue}, 32'd0);
        check("uf_set", 32'(underflow), 32'd1);
        wait_cnt("wait_f2_bursts", 1, b0 + 16);
        beat_gate = 3;
        for (int i = 0; i < 8; i++) pop_expect("f2_pixel", 24'hC00 + 24'(i));

        // Restart while the third burst is stalled after three beats
        wait_cnt("wait_f2_third_req", 0, r0 + 3);
        wait_cnt("wait_three_beats", 2, 3);
        tick(5);
        check("burst_stalled", 32'(n_done), 32'(d0 + 2));
        beat_gate = 8;
        frame_pulse(32'h2000);
        check("restart_uf_clear", 32'(underflow), 32'd0);
        gate_release = 1'b1;
        wait_cnt("wait_drain", 3, d0 + 3);
        gate_release = 1'b0;
        wait_cnt("wait_restart_req", 0, r0 + 4);
        check("restart_addr", req_addr[r0 + 3], 32'h2000);
        beat_gate = 3;
        wait_cnt("wait_restart_burst", 3, d0 + 4);
        pop_expect("restart_first_pixel", 24'h800);

        // fetch_en dropped mid-burst: burst completes, then fetching stops
        wait_cnt("wait_f3_second_req", 0, r0 + 5);
        check("f3_req1_addr", req_addr[r0 + 4], 32'h2020);
        wait_cnt("wait_f3_three_beats", 2, 3);
        tick(3);
        fetch_en     = 1'b0;
        gate_release = 1'b1;
        wait_cnt("wait_f3_burst_end", 3, d0 + 5);
        gate_release = 1'b0;
        for (int i = 1; i < 16; i++) pop_expect("f3_pixel", 24'h800 + 24'(i));
        tick(30);
        check("stopped_req_count", 32'(n_req), 32'(r0 + 5));
        check("stopped_req_low", 32'(mem_req), 32'd0);
        pixel(1'b1);
        check("stopped_underflow", 32'(underflow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
